// File: rtl/definitions.sv
// Shared types for the pattern-check unit.
// Window positions are 1-based; NONE encodes "no match".
package definitions;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    POS3 = 3'd3,
    POS4 = 3'd4,
    POS5 = 3'd5
  } BitPosition_mne;

  localparam int NumWin = 5;

endpackage

// File: rtl/patr_window.sv
// Single 4-bit window comparator.
// Exact equality; no wildcard bits.
module patr_window (
  input  logic [3:0] window,
  input  logic [3:0] pattern,
  output logic       match
);

  assign match = (window == pattern);

endmodule

// File: rtl/patr.sv
// Pattern-check unit: finds a nibble in five byte windows.
// Reports hit, lowest hit position and hit count, registered.
module patr
  import definitions::*;
(
  input  logic           CLK,
  input  logic           reset,
  input  logic [7:0]     PatrSrcA,
  input  logic [7:0]     PatrSrcB,
  output logic           PatrOut,
  output BitPosition_mne PatrPos,
  output logic [2:0]     PatrCount
);

  logic [NumWin:1] match;
  BitPosition_mne  posNext;
  logic [2:0]      countNext;
  logic            unusedB;

  // Only the low nibble of B carries the pattern.
  assign unusedB = ^PatrSrcB[7:4];

  for (genvar k = 1; k <= NumWin; k++) begin : gWin
    patr_window uWin (
      .window  (PatrSrcA[k+2:k-1]),
      .pattern (PatrSrcB[3:0]),
      .match   (match[k])
    );
  end

  // Overlapping hits are legal, so priority rather than unique.
  always_comb begin
    posNext = NONE;
    priority case (1'b1)
      match[1]: posNext = POS1;
      match[2]: posNext = POS2;
      match[3]: posNext = POS3;
      match[4]: posNext = POS4;
      match[5]: posNext = POS5;
      default:  posNext = NONE;
    endcase
  end

  always_comb begin
    countNext = '0;
    for (int k = 1; k <= NumWin; k++) begin
      countNext = countNext + {2'b00, match[k]};
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      PatrOut   <= 1'b0;
      PatrPos   <= NONE;
      PatrCount <= '0;
    end else begin
      PatrOut   <= |match;
      PatrPos   <= posNext;
      PatrCount <= countNext;
    end
  end

endmodule

// File: tb/tb_patr.sv
// Directed bench for patr.
// Expected values are hand-computed per vector.
module tb_patr;
  import definitions::*;

  logic           CLK;
  logic           reset;
  logic [7:0]     PatrSrcA;
  logic [7:0]     PatrSrcB;
  logic           PatrOut;
  BitPosition_mne PatrPos;
  logic [2:0]     PatrCount;

  int compared;
  int mismatched;

  patr dut (
    .CLK       (CLK),
    .reset     (reset),
    .PatrSrcA  (PatrSrcA),
    .PatrSrcB  (PatrSrcB),
    .PatrOut   (PatrOut),
    .PatrPos   (PatrPos),
    .PatrCount (PatrCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string          tag,
    input logic           eOut,
    input BitPosition_mne ePos,
    input logic [2:0]     eCnt
  );
    compared++;
    assert ({PatrOut, PatrPos, PatrCount} === {eOut, ePos, eCnt})
    else begin
      mismatched++;
      $error("FAIL %s: got out=%0b pos=%0d cnt=%0d, want out=%0b pos=%0d cnt=%0d",
             tag, PatrOut, PatrPos, PatrCount, eOut, ePos, eCnt);
    end
  endtask

  task automatic step(
    input logic [7:0] a,
    input logic [7:0] b
  );
    @(negedge CLK);
    PatrSrcA = a;
    PatrSrcB = b;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    PatrSrcA   = 8'h0A;
    PatrSrcB   = 8'h0A;

    // Reset held while a matching input is present.
    @(posedge CLK);
    #1 check("rst0", 1'b0, NONE, 3'd0);
    @(posedge CLK);
    #1 check("rst1", 1'b0, NONE, 3'd0);
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1 check("rstRel", 1'b1, POS1, 3'd1);

    step(8'h00, 8'h0A); check("miss0", 1'b0, NONE, 3'd0);
    step(8'h14, 8'h0A); check("pos2",  1'b1, POS2, 3'd1);
    step(8'h00, 8'h0A); check("miss1", 1'b0, NONE, 3'd0);
    step(8'h28, 8'h0A); check("pos3",  1'b1, POS3, 3'd1);
    step(8'h00, 8'h0A); check("miss2", 1'b0, NONE, 3'd0);
    step(8'h50, 8'h0A); check("pos4",  1'b1, POS4, 3'd1);
    step(8'h00, 8'h0A); check("miss3", 1'b0, NONE, 3'd0);
    step(8'hA0, 8'h0A); check("pos5",  1'b1, POS5, 3'd1);
    step(8'h00, 8'h0A); check("miss4", 1'b0, NONE, 3'd0);

    step(8'h0A, 8'hFA); check("junkB", 1'b1, POS1, 3'd1);
    step(8'hAA, 8'h0A); check("ovlAA", 1'b1, POS1, 3'd3);
    step(8'h55, 8'h0A); check("ovl55", 1'b1, POS2, 3'd2);
    step(8'h00, 8'h00); check("zero5", 1'b1, POS1, 3'd5);
    step(8'h00, 8'h0F); check("noF",   1'b0, NONE, 3'd0);
    step(8'hFF, 8'hCF); check("allF",  1'b1, POS1, 3'd5);
    step(8'h00, 8'h0F); check("noF2",  1'b0, NONE, 3'd0);

    // Latency: new input must not show before the edge.
    @(negedge CLK);
    PatrSrcA = 8'hA0;
    PatrSrcB = 8'h0A;
    #1 check("latPre", 1'b0, NONE, 3'd0);
    @(posedge CLK);
    #1 check("latPost", 1'b1, POS5, 3'd1);
    // Mid-cycle change must not leak through.
    #2 PatrSrcA = 8'h00;
    #1 check("midHold", 1'b1, POS5, 3'd1);
    @(posedge CLK);
    #1 check("midNext", 1'b0, NONE, 3'd0);

    // Reset wins over a matching input.
    @(negedge CLK);
    PatrSrcA = 8'h55;
    reset    = 1'b1;
    @(posedge CLK);
    #1 check("rstWin", 1'b0, NONE, 3'd0);
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1 check("rstAfter", 1'b1, POS2, 3'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
